// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - redirect, instruction-bus and decode signals grouped for fetch_ctrl
interface fetch_ctrl_if;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_ready;

  modport master (
    input  redirect_valid, redirect_pc, iresp_data_ok, iresp_data, instr_ready,
    output ireq_valid, ireq_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, iresp_data_ok, iresp_data, instr_ready,
    input  ireq_valid, ireq_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - single-outstanding instruction fetch FSM with redirect handling
// Holds one fetched word for decode; responses to redirected-away requests are drained.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_addr_q, req_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] instr_pc_q, instr_pc_d;
  logic [63:0] redir_pc;

  assign redir_pc = bus.redirect_pc & ~64'h3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    unique case (state_q)
      IDLE: begin
        req_addr_d = pc_q;
        state_d    = FETCH;
      end
      FETCH: begin
        if (bus.iresp_data_ok && bus.redirect_valid) begin
          pc_d       = redir_pc;
          req_addr_d = redir_pc;
        end else if (bus.iresp_data_ok) begin
          instr_d    = bus.iresp_data;
          instr_pc_d = req_addr_q;
          pc_d       = req_addr_q + 64'd4;
          state_d    = HOLD;
        end else if (bus.redirect_valid) begin
          // Request stays on the bus until its response arrives, then is thrown away.
          pc_d    = redir_pc;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.redirect_valid) begin
          pc_d = redir_pc;
        end
        if (bus.iresp_data_ok) begin
          req_addr_d = bus.redirect_valid ? redir_pc : pc_q;
          state_d    = FETCH;
        end
      end
      HOLD: begin
        if (bus.redirect_valid) begin
          pc_d       = redir_pc;
          req_addr_d = redir_pc;
          state_d    = FETCH;
        end else if (bus.instr_ready) begin
          req_addr_d = pc_q;
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ireq_valid  = (state_q == FETCH) || (state_q == DRAIN);
  assign bus.ireq_addr   = req_addr_q;
  assign bus.instr_valid = (state_q == HOLD);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

endmodule
